// File: rtl/queue_rr_arbiter_if.sv
// Bundle of the requester-side and queue-side handshake signals of the
// round-robin burst arbiter. The master modport is the arbiter's view; the
// slave modport is the view of the surrounding producers and queue.
interface queue_rr_arbiter_if #(
   parameter int WIDTH    = 4096,
   parameter int NUM_REQ  = 4,
   parameter int CHOSEN_W = 2
);
   logic [NUM_REQ*WIDTH-1:0] io_in_bits;
   logic [NUM_REQ-1:0]       io_in_valid;
   logic [NUM_REQ-1:0]       io_in_ready;
   logic [WIDTH-1:0]         io_out_bits;
   logic                     io_out_valid;
   logic                     io_out_ready;
   logic [CHOSEN_W-1:0]      io_chosen;
   logic                     io_busy;

   modport master (
      input  io_in_bits, io_in_valid, io_out_ready,
      output io_in_ready, io_out_bits, io_out_valid, io_chosen, io_busy
   );

   modport slave (
      output io_in_bits, io_in_valid, io_out_ready,
      input  io_in_ready, io_out_bits, io_out_valid, io_chosen, io_busy
   );
endinterface

// File: rtl/queue_rr_arbiter.sv
// Round-robin burst arbiter sharing one wide enqueue port between NUM_REQ
// producers. A grant is held for up to BURST_LEN accepted beats, or until the
// holder drops valid, after which priority rotates to the next index.
// The data path is a pure combinational mux; nothing but control is stored.
module queue_rr_arbiter #(
   parameter int WIDTH     = 4096,
   parameter int NUM_REQ   = 4,
   parameter int BURST_LEN = 8,
   parameter int CHOSEN_W  = 2
) (
   input  logic                clock,
   input  logic                reset,
   queue_rr_arbiter_if.master  io
);
   localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam int CNT_W = $clog2(BURST_LEN + 1);

   typedef enum logic {IDLE, GRANT} state_t;

   state_t           state_q, state_d;
   logic [IDX_W-1:0] grant_idx_q, grant_idx_d;
   logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
   logic [CNT_W-1:0] beat_cnt_q, beat_cnt_d;

   logic [IDX_W-1:0] pick_idx;
   logic [IDX_W-1:0] pos_idx;
   logic [IDX_W-1:0] next_rr;
   logic             pick_found;
   logic             active;
   logic             holder_valid;
   logic             fire;
   int               pos;

   // Find the first valid requester starting at rr_ptr and wrapping around.
   always_comb begin
      pick_idx   = '0;
      pick_found = 1'b0;
      pos        = 0;
      pos_idx    = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         pos = int'(rr_ptr_q) + k;
         if (pos >= NUM_REQ) pos = pos - NUM_REQ;
         pos_idx = IDX_W'(pos);
         if (!pick_found && io.io_in_valid[pos_idx]) begin
            pick_idx   = pos_idx;
            pick_found = 1'b1;
         end
      end
   end

   // Drive the output side from the grant holder; everything reads zero
   // outside GRANT and while reset is asserted.
   always_comb begin
      active          = (state_q == GRANT) && !reset;
      holder_valid    = io.io_in_valid[grant_idx_q];
      io.io_out_valid = 1'b0;
      io.io_in_ready  = '0;
      io.io_out_bits  = '0;
      io.io_chosen    = '0;
      io.io_busy      = 1'b0;
      if (active) begin
         io.io_out_valid             = holder_valid;
         io.io_in_ready[grant_idx_q] = io.io_out_ready;
         io.io_chosen                = CHOSEN_W'(grant_idx_q);
         io.io_busy                  = 1'b1;
         for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_idx_q == IDX_W'(i)) io.io_out_bits = io.io_in_bits[i*WIDTH +: WIDTH];
         end
      end
      fire = io.io_out_valid & io.io_out_ready;
   end

   // Next-state logic: grant on any request, release on burst limit or idle holder.
   always_comb begin
      state_d     = state_q;
      grant_idx_d = grant_idx_q;
      rr_ptr_d    = rr_ptr_q;
      beat_cnt_d  = beat_cnt_q;
      next_rr     = (grant_idx_q == IDX_W'(NUM_REQ - 1)) ? '0 : grant_idx_q + 1'b1;
      case (state_q)
         IDLE: begin
            if (pick_found) begin
               grant_idx_d = pick_idx;
               beat_cnt_d  = '0;
               state_d     = GRANT;
            end
         end
         GRANT: begin
            if (!holder_valid || (fire && beat_cnt_q == CNT_W'(BURST_LEN - 1))) begin
               state_d    = IDLE;
               rr_ptr_d   = next_rr;
               beat_cnt_d = '0;
            end else if (fire) begin
               beat_cnt_d = beat_cnt_q + 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State register with synchronous reset.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q     <= IDLE;
         grant_idx_q <= '0;
         rr_ptr_q    <= '0;
         beat_cnt_q  <= '0;
      end else begin
         state_q     <= state_d;
         grant_idx_q <= grant_idx_d;
         rr_ptr_q    <= rr_ptr_d;
         beat_cnt_q  <= beat_cnt_d;
      end
   end
endmodule
